// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC instruction fetch unit: default widths,
// the reset fetch address and the fetch state encoding.
package sisc_pkg;

   localparam int ADDR_W_DEF   = 16;
   localparam int RESET_PC_DEF = 0;

   // REQ and WAIT both hold a memory request open; HOLD owns a live
   // instruction; HALT is left only through reset.
   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_HALT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/sisc_pc_reg.sv
// Fetch address register: synchronous reset to RESET_PC, load of a redirect
// target, or increment modulo 2^ADDR_W. Load wins over increment.
module sisc_pc_reg
   import sisc_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] value
);

   // Address update; the increment wraps naturally at the register width.
   always_ff @(posedge clk) begin
      if (rst_f) begin
         value <= RESET_PC;
      end else if (load) begin
         value <= load_val;
      end else if (inc) begin
         value <= value + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/sisc_ifetch.sv
// SISC instruction fetch unit. Requests one word at a time from instruction
// memory, holds it in ir until the core consumes it, and handles branch
// redirects (including ones that arrive while a request is outstanding) and
// halt.
module sisc_ifetch
   import sisc_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst_f,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_req,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_ack,
   output logic [31:0]       ir,
   output logic              ir_valid,
   input  logic              ir_next,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_addr,
   input  logic              halt,
   output logic [ADDR_W-1:0] pc
);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic              req_en;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_addr;
   logic [ADDR_W-1:0] fetch_pc;
   logic              pc_load;
   logic              pc_inc;
   logic [ADDR_W-1:0] pc_load_val;
   logic              capture;
   logic              clr_valid;
   logic              pend_set;
   logic              pend_clr;

   sisc_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_fetch_pc (
      .clk      (clk),
      .rst_f    (rst_f),
      .load     (pc_load),
      .inc      (pc_inc),
      .load_val (pc_load_val),
      .value    (fetch_pc)
   );

   // The address only moves on capture or redirect, so it is stable in WAIT.
   assign imem_addr = fetch_pc;

   // State register.
   always_ff @(posedge clk) begin
      if (rst_f) begin
         state <= ST_REQ;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and control. req_en keeps the request low for the first
   // cycle after reset so the bus sees a clean gap across reset.
   always_comb begin
      state_nxt   = state;
      imem_req    = 1'b0;
      pc_load     = 1'b0;
      pc_inc      = 1'b0;
      pc_load_val = br_addr;
      capture     = 1'b0;
      clr_valid   = 1'b0;
      pend_set    = 1'b0;
      pend_clr    = 1'b0;
      case (state)
         ST_REQ, ST_WAIT: begin
            if (req_en) begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  if (br_taken || pend_valid) begin
                     pc_load     = 1'b1;
                     pc_load_val = br_taken ? br_addr : pend_addr;
                     pend_clr    = 1'b1;
                     state_nxt   = ST_REQ;
                  end else begin
                     capture   = 1'b1;
                     pc_inc    = 1'b1;
                     state_nxt = ST_HOLD;
                  end
               end else begin
                  pend_set  = br_taken;
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_HOLD: begin
            if (halt) begin
               clr_valid = 1'b1;
               state_nxt = ST_HALT;
            end else if (br_taken) begin
               pc_load   = 1'b1;
               clr_valid = 1'b1;
               state_nxt = ST_REQ;
            end else if (ir_next) begin
               clr_valid = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_HALT: begin
            state_nxt = ST_HALT;
         end
         default: begin
            state_nxt = ST_REQ;
         end
      endcase
   end

   // Instruction capture, valid flag and the pending redirect target.
   always_ff @(posedge clk) begin
      if (rst_f) begin
         req_en     <= 1'b0;
         ir         <= 32'd0;
         pc         <= RESET_PC;
         ir_valid   <= 1'b0;
         pend_valid <= 1'b0;
         pend_addr  <= '0;
      end else begin
         req_en <= 1'b1;
         if (capture) begin
            ir       <= imem_rdata;
            pc       <= fetch_pc;
            ir_valid <= 1'b1;
         end else if (clr_valid) begin
            ir_valid <= 1'b0;
         end
         if (pend_clr) begin
            pend_valid <= 1'b0;
         end else if (pend_set) begin
            pend_valid <= 1'b1;
            pend_addr  <= br_addr;
         end
      end
   end

endmodule

// File: tb/tb_sisc_ifetch.sv
// Testbench for sisc_ifetch: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_sisc_ifetch;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk;
   logic        rst_f;
   logic [15:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] ir;
   logic        ir_valid;
   logic        ir_next;
   logic        br_taken;
   logic [15:0] br_addr;
   logic        halt;
   logic [15:0] pc;

   int total;
   int bad;

   // Reference model state.
   logic [15:0] m_fetch;
   logic [15:0] m_tgt;
   logic [15:0] m_pc;
   logic [31:0] m_ir;
   logic        m_pend;
   logic        m_valid;
   logic        m_halted;
   logic        m_armed;
   logic        m_checking;

   // Memory responder state.
   int ack_delay;
   int wait_cnt;
   logic rand_ack;

   sisc_ifetch #(
      .ADDR_W   (16),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk        (clk),
      .rst_f      (rst_f),
      .imem_addr  (imem_addr),
      .imem_req   (imem_req),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .ir         (ir),
      .ir_valid   (ir_valid),
      .ir_next    (ir_next),
      .br_taken   (br_taken),
      .br_addr    (br_addr),
      .halt       (halt),
      .pc         (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [15:0] a);
      return {a ^ 16'hC3A5, a + 16'h1357};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // One clock cycle: compare outputs with the model, drive the inputs and
   // the memory response, advance the model, then take the edge.
   task automatic applyStimulus(input logic rst, input logic br, input logic [15:0] ba,
                                input logic nxt, input logic hlt);
      logic ack;
      logic exp_req;
      @(negedge clk);
      exp_req = m_armed && !m_valid && !m_halted;
      if (m_checking) begin
         checkOutput("imem_req", imem_req, exp_req);
         if (exp_req) checkOutput("imem_addr", imem_addr, m_fetch);
         checkOutput("ir_valid", ir_valid, m_valid);
         checkOutput("ir", ir, m_ir);
         checkOutput("pc", pc, m_pc);
      end
      ack = 1'b0;
      if (rst) begin
         wait_cnt = 0;
      end else if (imem_req === 1'b1) begin
         if (wait_cnt >= ack_delay) begin
            ack = 1'b1;
            wait_cnt = 0;
            if (rand_ack) ack_delay = $urandom_range(0, 3);
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
      rst_f      = rst;
      imem_ack   = ack;
      imem_rdata = ack ? memWord(imem_addr) : 32'hDEAD_BEEF;
      br_taken   = br;
      br_addr    = ba;
      ir_next    = nxt;
      halt       = hlt;
      if (rst) begin
         m_fetch = RESET_PC; m_pc = RESET_PC; m_ir = 32'd0;
         m_valid = 1'b0; m_pend = 1'b0; m_halted = 1'b0; m_armed = 1'b0;
         m_checking = 1'b1;
      end else if (!m_armed) begin
         m_armed = 1'b1;
      end else if (m_halted) begin
         m_halted = 1'b1;
      end else if (!m_valid) begin
         if (br) begin
            m_pend = 1'b1;
            m_tgt  = ba;
         end
         if (ack) begin
            if (m_pend) begin
               m_fetch = m_tgt;
               m_pend  = 1'b0;
            end else begin
               m_valid = 1'b1;
               m_ir    = memWord(m_fetch);
               m_pc    = m_fetch;
               m_fetch = m_fetch + 16'd1;
            end
         end
      end else begin
         if (hlt) begin
            m_valid  = 1'b0;
            m_halted = 1'b1;
         end else if (br) begin
            m_fetch = ba;
            m_valid = 1'b0;
         end else if (nxt) begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
   endtask

   initial begin
      total = 0; bad = 0;
      rst_f = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
      ir_next = 1'b0; br_taken = 1'b0; br_addr = 16'd0; halt = 1'b0;
      m_fetch = RESET_PC; m_tgt = 16'd0; m_pc = RESET_PC; m_ir = 32'd0;
      m_pend = 1'b0; m_valid = 1'b0; m_halted = 1'b0; m_armed = 1'b0;
      m_checking = 1'b0;
      ack_delay = 0; wait_cnt = 0; rand_ack = 1'b0;

      // Reset, then release with a zero-latency memory.
      repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      #1;
      checkOutput("rel_req", imem_req, 1'b1);
      checkOutput("rel_addr", imem_addr, 16'h0000);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      #1;
      checkOutput("rel_valid", ir_valid, 1'b1);
      checkOutput("rel_ir", ir, memWord(16'h0000));
      checkOutput("rel_pc", pc, 16'h0000);

      // Three-cycle ack delay on address 0x0001.
      ack_delay = 3;
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
         #1;
         checkOutput("wait_addr", imem_addr, 16'h0001);
         checkOutput("wait_valid", ir_valid, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      #1;
      checkOutput("wait_ir", ir, memWord(16'h0001));

      // Branch from HOLD to 0x0040.
      ack_delay = 0;
      applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
      #1;
      checkOutput("brh_addr", imem_addr, 16'h0040);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      #1;
      checkOutput("brh_pc", pc, 16'h0040);

      // Branch to 0x0010 while waiting; late ack data is discarded.
      ack_delay = 2;
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      #1;
      checkOutput("brw_valid", ir_valid, 1'b0);
      checkOutput("brw_addr", imem_addr, 16'h0010);
      ack_delay = 0;
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      #1;
      checkOutput("brw_pc", pc, 16'h0010);

      // Wrap from 0xFFFF to 0x0000.
      applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      #1;
      checkOutput("wrap_pc", pc, 16'hFFFF);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      #1;
      checkOutput("wrap_addr", imem_addr, 16'h0000);

      // Halt together with ir_next, then restart through reset.
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         #1;
         checkOutput("halt_req", imem_req, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      #1;
      checkOutput("restart_req", imem_req, 1'b1);
      checkOutput("restart_addr", imem_addr, RESET_PC);

      // Random traffic against the model.
      rand_ack = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom_range(0, 199) == 0),
                       ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 63) == 0));
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
